// File: rtl/gate_pkg.sv
// Shared definitions for the gate-evaluation exercises and the shared arbiter.
//   - OP_*  : 2-bit opcodes of the four-input gate unit
//   - S_*   : state encodings of the arbiter sequencer
//   - odd_parity4 : helper returning the XOR of four bits
package gate_pkg;

    localparam logic [1:0] OP_NAND = 2'b00;
    localparam logic [1:0] OP_NOR  = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_XNOR = 2'b11;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_EVAL = 2'b01;
    localparam logic [1:0] S_RESP = 2'b10;

    function automatic logic odd_parity4(input logic [3:0] v);
        return v[3] ^ v[2] ^ v[1] ^ v[0];
    endfunction

endpackage

// File: rtl/gate_share_arbiter_gate_unit.sv
// four_input_gate_unit: purely combinational four-input gate.
//   a, b, c, d : operand bits (a is the most significant)
//   op         : OP_NAND / OP_NOR / OP_XOR / OP_XNOR
//   e          : gate output
module four_input_gate_unit
    import gate_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic [1:0] op,
    output logic       e
);

    // Opcode decode onto the selected gate function.
    always_comb begin
        e = 1'b0;
        case (op)
            OP_NAND: e = ~(a & b & c & d);
            OP_NOR:  e = ~(a | b | c | d);
            OP_XOR:  e = odd_parity4({a, b, c, d});
            OP_XNOR: e = ~odd_parity4({a, b, c, d});
            default: e = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_share_arbiter.sv
// gate_share_arbiter: round-robin sharing of one four-input gate unit.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   req       : per-requester request, held until ack
//   op, opnd  : per-requester opcode (2 bits) and operands a,b,c,d (4 bits)
//   gnt       : one-hot grant, high during EVAL
//   ack       : one-hot single-cycle acknowledge during RESP
//   result    : gate output for the acked requester (0 outside RESP)
//   res_id    : index of the acked requester (0 outside RESP)
//   busy      : high in EVAL and RESP
//   op_count  : completed operations, wraps at 16 bits
module gate_share_arbiter
    import gate_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] op,
    input  logic [4*NREQ-1:0] opnd,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   ack,
    output logic              result,
    output logic [IDW-1:0]    res_id,
    output logic              busy,
    output logic [15:0]       op_count
);

    logic [1:0]      state_q,  state_d;
    logic [IDW-1:0]  ptr_q,    ptr_d;
    logic [IDW-1:0]  win_q,    win_d;
    logic [1:0]      op_q,     op_d;
    logic [3:0]      opnd_q,   opnd_d;
    logic [NREQ-1:0] gnt_q,    gnt_d;
    logic [NREQ-1:0] ack_q,    ack_d;
    logic            result_q, result_d;
    logic [IDW-1:0]  res_id_q, res_id_d;
    logic            busy_q,   busy_d;
    logic [15:0]     cnt_q,    cnt_d;

    logic [IDW-1:0]  win_s;
    logic [1:0]      op_sel_s;
    logic [3:0]      opnd_sel_s;
    logic            gate_e_s;
    int              dist_s;
    int              best_s;

    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    // Round-robin pick: the requester with the smallest rotational distance
    // from ptr wins, so ptr itself has the highest priority.
    always_comb begin
        win_s  = '0;
        dist_s = 0;
        best_s = NREQ;
        for (int j = 0; j < NREQ; j++) begin
            if (req[j]) begin
                dist_s = (j + NREQ - int'(ptr_q)) % NREQ;
                if (dist_s < best_s) begin
                    best_s = dist_s;
                    win_s  = IDW'(j);
                end else begin
                    best_s = best_s;
                end
            end else begin
                dist_s = dist_s;
            end
        end
    end

    // Extract the winner's opcode and operands from the packed buses.
    always_comb begin
        op_sel_s   = 2'b00;
        opnd_sel_s = 4'b0000;
        for (int j = 0; j < NREQ; j++) begin
            if (win_s == IDW'(j)) begin
                op_sel_s   = op[2*j +: 2];
                opnd_sel_s = opnd[4*j +: 4];
            end else begin
                op_sel_s   = op_sel_s;
            end
        end
    end

    four_input_gate_unit u_gate (
        .a  (opnd_q[3]),
        .b  (opnd_q[2]),
        .c  (opnd_q[1]),
        .d  (opnd_q[0]),
        .op (op_q),
        .e  (gate_e_s)
    );

    // Sequencer next-state: IDLE latches a winner, EVAL registers the gate
    // output, RESP pulses ack and rotates the pointer past the winner.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        gnt_d    = gnt_q;
        ack_d    = ack_q;
        result_d = result_q;
        res_id_d = res_id_q;
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_EVAL;
                    win_d   = win_s;
                    op_d    = op_sel_s;
                    opnd_d  = opnd_sel_s;
                    gnt_d   = ONE_HOT0 << win_s;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EVAL: begin
                state_d  = S_RESP;
                gnt_d    = '0;
                ack_d    = ONE_HOT0 << win_q;
                result_d = gate_e_s;
                res_id_d = win_q;
            end
            S_RESP: begin
                state_d  = S_IDLE;
                ack_d    = '0;
                result_d = 1'b0;
                res_id_d = '0;
                busy_d   = 1'b0;
                cnt_d    = cnt_q + 16'd1;
                ptr_d    = (win_q == IDW'(NREQ-1)) ? '0 : win_q + IDW'(1);
            end
            default: begin
                state_d  = S_IDLE;
                gnt_d    = '0;
                ack_d    = '0;
                result_d = 1'b0;
                res_id_d = '0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            win_q    <= '0;
            op_q     <= 2'b00;
            opnd_q   <= 4'b0000;
            gnt_q    <= '0;
            ack_q    <= '0;
            result_q <= 1'b0;
            res_id_q <= '0;
            busy_q   <= 1'b0;
            cnt_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            result_q <= result_d;
            res_id_q <= res_id_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
        end
    end

    assign gnt      = gnt_q;
    assign ack      = ack_q;
    assign result   = result_q;
    assign res_id   = res_id_q;
    assign busy     = busy_q;
    assign op_count = cnt_q;

endmodule
